// File: rtl/picorv32_pcpi_pkg.sv
// Shared definitions for the PCPI arbiter and the MUL/DIV coprocessors:
// FSM state type, RV32M decode constants and the per-port request record.
package picorv32_pcpi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BUSY_MUL = 3'd1,
        BUSY_DIV = 3'd2,
        DONE     = 3'd3,
        DRAIN    = 3'd4
    } pcpi_state_e;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // funct3[2] of an R-type instruction selects the divider group
    localparam int ROUTE_BIT = 14;

    localparam int BUSY_CNT_W = 7;
    localparam int NUM_PORTS  = 2;
    localparam int PORT_MUL   = 0;
    localparam int PORT_DIV   = 1;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } pcpi_req_t;

endpackage

// File: rtl/picorv32_pcpi_decode.sv
// Combinational RV32M decoder: claims MUL/DIV-group instructions and
// reports which group (multiplier or divider) should execute them.
module picorv32_pcpi_decode
    import picorv32_pcpi_pkg::*;
(
    input  logic [31:0] i_insn,
    output logic        o_claim,
    output logic        o_route_div
);

    logic w_unused_fields;

    assign o_claim     = (i_insn[6:0] == OPCODE_OP) && (i_insn[31:25] == FUNCT7_MULDIV);
    assign o_route_div = i_insn[ROUTE_BIT];

    assign w_unused_fields = ^{i_insn[24:15], i_insn[13:7]};

endmodule

// File: rtl/picorv32_pcpi_arbiter.sv
// Routes claimed RV32M PCPI requests to a MUL or DIV coprocessor port,
// returns the result to the core and aborts hung or withdrawn requests.
module picorv32_pcpi_arbiter
    import picorv32_pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready,

    output logic        mul_valid,
    output logic [31:0] mul_insn,
    output logic [31:0] mul_rs1,
    output logic [31:0] mul_rs2,
    input  logic        mul_wr,
    input  logic [31:0] mul_rd,
    input  logic        mul_wait,
    input  logic        mul_ready,

    output logic        div_valid,
    output logic [31:0] div_insn,
    output logic [31:0] div_rs1,
    output logic [31:0] div_rs2,
    input  logic        div_wr,
    input  logic [31:0] div_rd,
    input  logic        div_wait,
    input  logic        div_ready,

    output logic        timeout_evt
);

    localparam logic [BUSY_CNT_W:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    pcpi_state_e r_state;
    pcpi_state_e w_state_next;

    logic [BUSY_CNT_W-1:0] r_busy_cnt;
    logic [BUSY_CNT_W-1:0] w_busy_cnt_next;
    logic [BUSY_CNT_W:0]   w_cnt_inc;

    logic        r_pcpi_wr;
    logic [31:0] r_pcpi_rd;
    logic        r_pcpi_wait;
    logic        r_pcpi_ready;
    logic        r_timeout_evt;

    logic        w_claim;
    logic        w_route_div;
    logic        w_in_busy;
    logic        w_timeout;
    logic        w_accept;
    logic        w_complete;
    logic        w_abort_timeout;
    logic        w_port_ready;
    logic        w_port_wr;
    logic [31:0] w_port_rd;
    logic        w_unused_wait;

    pcpi_req_t   w_req       [NUM_PORTS];
    logic        w_port_valid[NUM_PORTS];

    picorv32_pcpi_decode u_decode (
        .i_insn      (pcpi_insn),
        .o_claim     (w_claim),
        .o_route_div (w_route_div)
    );

    assign w_in_busy     = (r_state == BUSY_MUL) || (r_state == BUSY_DIV);
    assign w_cnt_inc     = {1'b0, r_busy_cnt} + 1'b1;
    assign w_timeout     = w_in_busy && (w_cnt_inc >= TIMEOUT_LIM);
    assign w_unused_wait = mul_wait | div_wait;

    // Only the port owning the current BUSY state is listened to.
    always_comb begin
        w_port_ready = 1'b0;
        w_port_wr    = 1'b0;
        w_port_rd    = '0;
        if (r_state == BUSY_MUL) begin
            w_port_ready = mul_ready;
            w_port_wr    = mul_wr;
            w_port_rd    = mul_rd;
        end else if (r_state == BUSY_DIV) begin
            w_port_ready = div_ready;
            w_port_wr    = div_wr;
            w_port_rd    = div_rd;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Withdrawal by the core beats a port response, which beats the timeout.
    always_comb begin
        w_state_next    = r_state;
        w_accept        = 1'b0;
        w_complete      = 1'b0;
        w_abort_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (pcpi_valid && w_claim) begin
                    w_accept     = 1'b1;
                    w_state_next = w_route_div ? BUSY_DIV : BUSY_MUL;
                end
            end
            BUSY_MUL, BUSY_DIV: begin
                if (!pcpi_valid) begin
                    w_state_next = IDLE;
                end else if (w_port_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = DONE;
                end else if (w_timeout) begin
                    w_abort_timeout = 1'b1;
                    w_state_next    = DRAIN;
                end
            end
            DONE: begin
                w_state_next = DRAIN;
            end
            DRAIN: begin
                if (!pcpi_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy_cnt_next = r_busy_cnt;
        if (w_accept) begin
            w_busy_cnt_next = '0;
        end else if (w_in_busy && (r_busy_cnt != '1)) begin
            w_busy_cnt_next = w_cnt_inc[BUSY_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy_cnt    <= '0;
            r_pcpi_wr     <= 1'b0;
            r_pcpi_rd     <= '0;
            r_pcpi_wait   <= 1'b0;
            r_pcpi_ready  <= 1'b0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_busy_cnt    <= w_busy_cnt_next;
            r_pcpi_wait   <= (w_state_next == BUSY_MUL) || (w_state_next == BUSY_DIV);
            r_pcpi_ready  <= w_complete;
            r_pcpi_wr     <= w_complete & w_port_wr;
            r_timeout_evt <= w_abort_timeout;
            if (w_complete) begin
                r_pcpi_rd <= w_port_rd;
            end
        end
    end

    // Per-port request registers; cleared whenever the port is not being served.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            localparam pcpi_state_e BUSY_ST = (gi == PORT_DIV) ? BUSY_DIV : BUSY_MUL;

            pcpi_req_t r_req;
            logic      r_valid;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_req   <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= (w_state_next == BUSY_ST);
                    if (w_accept && (w_state_next == BUSY_ST)) begin
                        r_req <= {pcpi_insn, pcpi_rs1, pcpi_rs2};
                    end else if (w_state_next != BUSY_ST) begin
                        r_req <= '0;
                    end
                end
            end

            assign w_req[gi]        = r_req;
            assign w_port_valid[gi] = r_valid;
        end
    endgenerate

    assign mul_valid   = w_port_valid[PORT_MUL];
    assign mul_insn    = w_req[PORT_MUL].insn;
    assign mul_rs1     = w_req[PORT_MUL].rs1;
    assign mul_rs2     = w_req[PORT_MUL].rs2;

    assign div_valid   = w_port_valid[PORT_DIV];
    assign div_insn    = w_req[PORT_DIV].insn;
    assign div_rs1     = w_req[PORT_DIV].rs1;
    assign div_rs2     = w_req[PORT_DIV].rs2;

    assign pcpi_wr     = r_pcpi_wr;
    assign pcpi_rd     = r_pcpi_rd;
    assign pcpi_wait   = r_pcpi_wait;
    assign pcpi_ready  = r_pcpi_ready;
    assign timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_picorv32_pcpi_arbiter.sv
// Directed bench: dut A uses the default timeout, dut B a short timeout of 8;
// both see identical stimulus and stay in step between scenarios.
module tb_picorv32_pcpi_arbiter;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        resetn;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        mul_wr, mul_wait, mul_ready;
    logic [31:0] mul_rd;
    logic        div_wr, div_wait, div_ready;
    logic [31:0] div_rd;

    logic        a_pcpi_wr, a_pcpi_wait, a_pcpi_ready, a_timeout_evt;
    logic [31:0] a_pcpi_rd;
    logic        a_mul_valid, a_div_valid;
    logic [31:0] a_mul_insn, a_mul_rs1, a_mul_rs2, a_div_insn, a_div_rs1, a_div_rs2;

    logic        b_pcpi_wr, b_pcpi_wait, b_pcpi_ready, b_timeout_evt;
    logic [31:0] b_pcpi_rd;
    logic        b_mul_valid, b_div_valid;
    logic [31:0] b_mul_insn, b_mul_rs1, b_mul_rs2, b_div_insn, b_div_rs1, b_div_rs2;

    logic a_any, b_any;
    assign a_any = |{a_pcpi_wr, a_pcpi_rd, a_pcpi_wait, a_pcpi_ready, a_timeout_evt, a_mul_valid,
                     a_div_valid, a_mul_insn, a_mul_rs1, a_mul_rs2, a_div_insn, a_div_rs1, a_div_rs2};
    assign b_any = |{b_pcpi_wr, b_pcpi_rd, b_pcpi_wait, b_pcpi_ready, b_timeout_evt, b_mul_valid,
                     b_div_valid, b_mul_insn, b_mul_rs1, b_mul_rs2, b_div_insn, b_div_rs1, b_div_rs2};

    int checks = 0;
    int errors = 0;

    picorv32_pcpi_arbiter u_dut_a (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(a_pcpi_wr), .pcpi_rd(a_pcpi_rd), .pcpi_wait(a_pcpi_wait), .pcpi_ready(a_pcpi_ready),
        .mul_valid(a_mul_valid), .mul_insn(a_mul_insn), .mul_rs1(a_mul_rs1), .mul_rs2(a_mul_rs2),
        .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait), .mul_ready(mul_ready),
        .div_valid(a_div_valid), .div_insn(a_div_insn), .div_rs1(a_div_rs1), .div_rs2(a_div_rs2),
        .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
        .timeout_evt(a_timeout_evt)
    );

    picorv32_pcpi_arbiter #(.TIMEOUT_CYCLES(8)) u_dut_b (
        .clk(clk), .resetn(resetn),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(b_pcpi_wr), .pcpi_rd(b_pcpi_rd), .pcpi_wait(b_pcpi_wait), .pcpi_ready(b_pcpi_ready),
        .mul_valid(b_mul_valid), .mul_insn(b_mul_insn), .mul_rs1(b_mul_rs1), .mul_rs2(b_mul_rs2),
        .mul_wr(mul_wr), .mul_rd(mul_rd), .mul_wait(mul_wait), .mul_ready(mul_ready),
        .div_valid(b_div_valid), .div_insn(b_div_insn), .div_rs1(b_div_rs1), .div_rs2(b_div_rs2),
        .div_wr(div_wr), .div_rd(div_rd), .div_wait(div_wait), .div_ready(div_ready),
        .timeout_evt(b_timeout_evt)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
        mul_wr = 1'b0; mul_rd = '0; mul_wait = 1'b0; mul_ready = 1'b0;
        div_wr = 1'b0; div_rd = '0; div_wait = 1'b0; div_ready = 1'b0;
    endtask

    task automatic release_core();
        pcpi_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        tick();
        tick();
        checks++; if (a_any !== 1'b0) begin errors++; $display("FAIL reset_a_outputs got %b need 0", a_any); end
        checks++; if (b_any !== 1'b0) begin errors++; $display("FAIL reset_b_outputs got %b need 0", b_any); end
        resetn = 1'b1;
        tick();
        $display("test_reset: outputs a=%b b=%b", a_any, b_any);
    endtask

    task automatic test_unclaimed();
        int nz;
        nz = 0;
        pcpi_valid = 1'b1; pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd6;
        mul_ready = 1'b1; mul_rd = 32'h11; mul_wr = 1'b1;
        div_ready = 1'b1; div_rd = 32'h22; div_wr = 1'b1;
        for (int c = 0; c < 20; c++) begin
            pcpi_insn = (c < 10) ? mk_insn(7'b0000000, 3'b000, OP_R) : mk_insn(7'b0000001, 3'b000, OP_IMM);
            tick();
            nz += int'(a_any) + int'(b_any);
        end
        checks++; if (nz !== 0) begin errors++; $display("FAIL unclaimed_outputs got %0d nonzero cycles need 0", nz); end
        idle_inputs();
        tick();
        $display("test_unclaimed: nonzero_cycles=%0d", nz);
    endtask

    task automatic test_mul();
        logic [31:0] exp_insn;
        logic        div_seen;
        exp_insn = mk_insn(7'b0000001, 3'b000, OP_R);
        div_seen = 1'b0;
        pcpi_insn = exp_insn; pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd6; pcpi_valid = 1'b1;
        tick();
        div_seen |= a_div_valid;
        checks++; if (a_mul_valid !== 1'b1) begin errors++; $display("FAIL mul_c1_valid got %b need 1", a_mul_valid); end
        checks++; if (a_pcpi_wait !== 1'b1) begin errors++; $display("FAIL mul_c1_wait got %b need 1", a_pcpi_wait); end
        checks++; if ({a_mul_insn, a_mul_rs1, a_mul_rs2} !== {exp_insn, 32'd7, 32'd6}) begin
            errors++; $display("FAIL mul_c1_req got %h %0d %0d need %h 7 6", a_mul_insn, a_mul_rs1, a_mul_rs2, exp_insn);
        end
        tick();
        div_seen |= a_div_valid;
        div_ready = 1'b1; div_rd = 32'hdead; div_wr = 1'b1;
        tick();
        div_seen |= a_div_valid;
        checks++; if (a_pcpi_ready !== 1'b0) begin errors++; $display("FAIL mul_foreign_ready got %b need 0", a_pcpi_ready); end
        checks++; if (a_pcpi_wait !== 1'b1) begin errors++; $display("FAIL mul_c3_wait got %b need 1", a_pcpi_wait); end
        checks++; if (a_mul_insn !== exp_insn) begin errors++; $display("FAIL mul_c3_insn_stable got %h need %h", a_mul_insn, exp_insn); end
        div_ready = 1'b0; div_wr = 1'b0;
        mul_ready = 1'b1; mul_rd = 32'd42; mul_wr = 1'b1;
        tick();
        div_seen |= a_div_valid;
        checks++; if ({a_pcpi_ready, a_pcpi_wr} !== 2'b11) begin errors++; $display("FAIL mul_c4_ready_wr got %b need 11", {a_pcpi_ready, a_pcpi_wr}); end
        checks++; if (a_pcpi_rd !== 32'd42) begin errors++; $display("FAIL mul_c4_rd got %0d need 42", a_pcpi_rd); end
        checks++; if ({a_pcpi_wait, a_mul_valid} !== 2'b00) begin errors++; $display("FAIL mul_c4_wait_valid got %b need 00", {a_pcpi_wait, a_mul_valid}); end
        checks++; if (b_pcpi_rd !== 32'd42) begin errors++; $display("FAIL mul_c4_rd_b got %0d need 42", b_pcpi_rd); end
        mul_ready = 1'b0; mul_wr = 1'b0; pcpi_valid = 1'b0;
        tick();
        div_seen |= a_div_valid;
        checks++; if ({a_pcpi_ready, a_pcpi_wr} !== 2'b00) begin errors++; $display("FAIL mul_c5_ready_wr got %b need 00", {a_pcpi_ready, a_pcpi_wr}); end
        checks++; if (a_pcpi_rd !== 32'd42) begin errors++; $display("FAIL mul_rd_hold got %0d need 42", a_pcpi_rd); end
        checks++; if (div_seen !== 1'b0) begin errors++; $display("FAIL mul_div_valid_seen got %b need 0", div_seen); end
        tick();
        $display("test_mul: rd=%0d", a_pcpi_rd);
    endtask

    task automatic test_div();
        int   wait_cnt;
        int   ready_cnt;
        logic mul_seen, early_ready, redispatch;
        wait_cnt = 0; ready_cnt = 0; mul_seen = 1'b0; early_ready = 1'b0; redispatch = 1'b0;
        pcpi_insn = mk_insn(7'b0000001, 3'b100, OP_R); pcpi_rs1 = 32'd100; pcpi_rs2 = 32'd7; pcpi_valid = 1'b1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            tick();
            wait_cnt += int'(a_pcpi_wait);
            mul_seen |= a_mul_valid;
            early_ready |= a_pcpi_ready;
            if (cyc == 1) begin
                checks++; if ({a_div_valid, a_div_rs1, a_div_rs2} !== {1'b1, 32'd100, 32'd7}) begin
                    errors++; $display("FAIL div_c1_req got %b %0d %0d need 1 100 7", a_div_valid, a_div_rs1, a_div_rs2);
                end
            end
            if (cyc == 36) begin
                div_ready = 1'b1; div_rd = 32'd14; div_wr = 1'b1;
            end
        end
        tick();
        div_ready = 1'b0; div_wr = 1'b0;
        checks++; if ({a_pcpi_ready, a_pcpi_wr} !== 2'b11) begin errors++; $display("FAIL div_c37_ready_wr got %b need 11", {a_pcpi_ready, a_pcpi_wr}); end
        checks++; if (a_pcpi_rd !== 32'd14) begin errors++; $display("FAIL div_c37_rd got %0d need 14", a_pcpi_rd); end
        checks++; if ({a_pcpi_wait, a_div_valid} !== 2'b00) begin errors++; $display("FAIL div_c37_wait_valid got %b need 00", {a_pcpi_wait, a_div_valid}); end
        checks++; if (wait_cnt !== 36) begin errors++; $display("FAIL div_wait_cycles got %0d need 36", wait_cnt); end
        checks++; if ({mul_seen, early_ready} !== 2'b00) begin errors++; $display("FAIL div_mul_or_early got %b need 00", {mul_seen, early_ready}); end
        for (int c = 0; c < 3; c++) begin
            tick();
            ready_cnt += int'(a_pcpi_ready);
            redispatch |= a_div_valid | a_mul_valid | a_pcpi_wait;
        end
        checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL div_drain_ready got %0d need 0", ready_cnt); end
        checks++; if (redispatch !== 1'b0) begin errors++; $display("FAIL div_drain_redispatch got %b need 0", redispatch); end
        pcpi_valid = 1'b0;
        tick();
        $display("test_div: rd=%0d wait_cycles=%0d", a_pcpi_rd, wait_cnt);
    endtask

    task automatic test_timeout();
        int   active_cnt;
        logic evt_early;
        active_cnt = 0; evt_early = 1'b0;
        pcpi_insn = mk_insn(7'b0000001, 3'b001, OP_R); pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd4; pcpi_valid = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            active_cnt += int'(b_mul_valid);
            evt_early |= b_timeout_evt;
        end
        tick();
        checks++; if (b_timeout_evt !== 1'b1) begin errors++; $display("FAIL to_evt got %b need 1", b_timeout_evt); end
        checks++; if ({b_mul_valid, b_pcpi_wait, b_pcpi_ready, b_pcpi_wr} !== 4'b0000) begin
            errors++; $display("FAIL to_outputs got %b need 0000", {b_mul_valid, b_pcpi_wait, b_pcpi_ready, b_pcpi_wr});
        end
        checks++; if ({a_mul_valid, a_timeout_evt} !== 2'b10) begin errors++; $display("FAIL to_long_dut got %b need 10", {a_mul_valid, a_timeout_evt}); end
        checks++; if ({active_cnt, evt_early} !== {32'd8, 1'b0}) begin errors++; $display("FAIL to_busy_span got %0d %b need 8 0", active_cnt, evt_early); end
        tick();
        checks++; if ({b_timeout_evt, b_mul_valid} !== 2'b00) begin errors++; $display("FAIL to_pulse_width got %b need 00", {b_timeout_evt, b_mul_valid}); end
        pcpi_valid = 1'b0;
        tick();
        checks++; if ({a_mul_valid, a_pcpi_wait, a_timeout_evt} !== 3'b000) begin
            errors++; $display("FAIL abort_outputs got %b need 000", {a_mul_valid, a_pcpi_wait, a_timeout_evt});
        end
        mul_ready = 1'b1; mul_rd = 32'd99; mul_wr = 1'b1;
        tick();
        checks++; if ({a_pcpi_ready, b_pcpi_ready} !== 2'b00) begin errors++; $display("FAIL late_ready got %b need 00", {a_pcpi_ready, b_pcpi_ready}); end
        mul_ready = 1'b0; mul_wr = 1'b0;
        pcpi_insn = mk_insn(7'b0000001, 3'b000, OP_R); pcpi_rs1 = 32'd3; pcpi_rs2 = 32'd5; pcpi_valid = 1'b1;
        tick();
        checks++; if (b_mul_valid !== 1'b1) begin errors++; $display("FAIL to_next_accept got %b need 1", b_mul_valid); end
        mul_ready = 1'b1; mul_rd = 32'd15; mul_wr = 1'b1;
        tick();
        checks++; if ({b_pcpi_ready, b_pcpi_rd} !== {1'b1, 32'd15}) begin errors++; $display("FAIL to_next_done got %b %0d need 1 15", b_pcpi_ready, b_pcpi_rd); end
        mul_ready = 1'b0; mul_wr = 1'b0;
        release_core();
        $display("test_timeout: busy_cycles=%0d next_rd=%0d", active_cnt, b_pcpi_rd);
    endtask

    task automatic test_ready_wins();
        pcpi_insn = mk_insn(7'b0000001, 3'b011, OP_R); pcpi_rs1 = 32'd8; pcpi_rs2 = 32'd9; pcpi_valid = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            tick();
            if (cyc == 8) begin
                mul_ready = 1'b1; mul_rd = 32'd72; mul_wr = 1'b1;
            end
        end
        tick();
        mul_ready = 1'b0; mul_wr = 1'b0;
        checks++; if ({b_pcpi_ready, b_pcpi_wr, b_timeout_evt} !== 3'b110) begin
            errors++; $display("FAIL race_flags got %b need 110", {b_pcpi_ready, b_pcpi_wr, b_timeout_evt});
        end
        checks++; if (b_pcpi_rd !== 32'd72) begin errors++; $display("FAIL race_rd got %0d need 72", b_pcpi_rd); end
        tick();
        checks++; if (b_timeout_evt !== 1'b0) begin errors++; $display("FAIL race_late_evt got %b need 0", b_timeout_evt); end
        release_core();
        $display("test_ready_wins: rd=%0d", b_pcpi_rd);
    endtask

    task automatic test_async_reset();
        pcpi_insn = mk_insn(7'b0000001, 3'b000, OP_R); pcpi_rs1 = 32'd6; pcpi_rs2 = 32'd9; pcpi_valid = 1'b1;
        tick();
        tick();
        checks++; if (a_mul_valid !== 1'b1) begin errors++; $display("FAIL ar_pre_valid got %b need 1", a_mul_valid); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if ({a_mul_valid, a_pcpi_wait, b_mul_valid} !== 3'b000) begin
            errors++; $display("FAIL ar_immediate got %b need 000", {a_mul_valid, a_pcpi_wait, b_mul_valid});
        end
        pcpi_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        pcpi_valid = 1'b1;
        tick();
        checks++; if ({a_mul_valid, a_mul_rs1, a_mul_rs2} !== {1'b1, 32'd6, 32'd9}) begin
            errors++; $display("FAIL ar_reaccept got %b %0d %0d need 1 6 9", a_mul_valid, a_mul_rs1, a_mul_rs2);
        end
        tick();
        mul_ready = 1'b1; mul_rd = 32'd54; mul_wr = 1'b1;
        tick();
        checks++; if ({a_pcpi_ready, a_pcpi_wr, a_pcpi_rd} !== {2'b11, 32'd54}) begin
            errors++; $display("FAIL ar_done got %b %b %0d need 1 1 54", a_pcpi_ready, a_pcpi_wr, a_pcpi_rd);
        end
        mul_ready = 1'b0; mul_wr = 1'b0;
        release_core();
        $display("test_async_reset: rd=%0d", a_pcpi_rd);
    endtask

    initial begin
        test_reset();
        test_unclaimed();
        test_mul();
        test_div();
        test_timeout();
        test_ready_wins();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
